// File: rtl/pause_ctrl.sv
// pause_ctrl: user/host pause arbitration, single-frame stepping and
// screen dimming after a long user pause. All logic on rising clk_sys.
module pause_ctrl #(
  parameter int unsigned SRC_COUNT   = 1,
  parameter int unsigned COLOR_W     = 4,
  parameter int unsigned DIM_TIMEOUT = 240000000,
  parameter int unsigned DIM_STEP    = 24000000,
  parameter int unsigned DIM_MAX     = 1,
  localparam int unsigned DIM_W      = $clog2(DIM_MAX + 1)
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   user_pause,
  input  logic                   user_step,
  input  logic [SRC_COUNT-1:0]   pause_req,
  input  logic                   osd_pause_en,
  input  logic                   osd_status,
  input  logic                   vblank,
  input  logic [3*COLOR_W-1:0]   rgb_in,
  output logic [3*COLOR_W-1:0]   rgb_out,
  output logic                   pause,
  output logic                   user_paused,
  output logic [DIM_W-1:0]       dim_level
);

  localparam int unsigned TIMER_W = $clog2(DIM_TIMEOUT + 1);
  localparam int unsigned STEP_W  = $clog2(DIM_STEP + 1);

  localparam logic [TIMER_W-1:0] TIMEOUT_V = TIMER_W'(DIM_TIMEOUT);
  localparam logic [STEP_W-1:0]  STEP_V    = STEP_W'(DIM_STEP);
  localparam logic [DIM_W-1:0]   DIM_MAX_V = DIM_W'(DIM_MAX);

  typedef enum logic [1:0] {
    S_RUN,
    S_PAUSED,
    S_STEP_A,
    S_STEP_B
  } state_t;

  state_t               state_q, state_d;
  logic                 pause_btn_q, pause_btn_d;
  logic                 step_btn_q, step_btn_d;
  logic                 vblank_q, vblank_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [STEP_W-1:0]    step_cnt_q, step_cnt_d;
  logic [DIM_W-1:0]     dim_q, dim_d;
  logic                 pause_q, pause_d;
  logic                 user_paused_q, user_paused_d;
  logic [3*COLOR_W-1:0] rgb_q, rgb_d;

  logic toggle_edge;
  logic step_edge;
  logic frame_edge;

  // Rising-edge detection against the previous-cycle copy of each input
  always_comb begin
    pause_btn_d = user_pause;
    step_btn_d  = user_step;
    vblank_d    = vblank;
    toggle_edge = user_pause & ~pause_btn_q;
    step_edge   = user_step & ~step_btn_q;
    frame_edge  = vblank & ~vblank_q;
  end

  // Next-state logic; a toggle always wins over step or vblank edges
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN: begin
        if (toggle_edge) state_d = S_PAUSED;
      end
      S_PAUSED: begin
        if (toggle_edge)    state_d = S_RUN;
        else if (step_edge) state_d = S_STEP_A;
      end
      S_STEP_A: begin
        if (toggle_edge)     state_d = S_RUN;
        else if (frame_edge) state_d = S_STEP_B;
      end
      S_STEP_B: begin
        if (toggle_edge)     state_d = S_RUN;
        else if (frame_edge) state_d = S_PAUSED;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Dim timer: counts only while staying in PAUSED, then steps the dim level
  always_comb begin
    timer_d    = timer_q;
    step_cnt_d = step_cnt_q;
    dim_d      = dim_q;
    if (state_q == S_PAUSED && state_d == S_PAUSED) begin
      if (timer_q != TIMEOUT_V) begin
        timer_d = timer_q + 1'b1;
        if (timer_d == TIMEOUT_V) dim_d = DIM_W'(1);
      end else if (dim_q != DIM_MAX_V) begin
        step_cnt_d = step_cnt_q + 1'b1;
        if (step_cnt_d == STEP_V) begin
          step_cnt_d = '0;
          dim_d      = dim_q + 1'b1;
        end
      end
    end else begin
      timer_d    = '0;
      step_cnt_d = '0;
      dim_d      = '0;
    end
  end

  // Registered outputs: pause sources, user-pause flag and dimmed pixel
  always_comb begin
    pause_d       = (state_q == S_PAUSED) | (|pause_req) | (osd_pause_en & osd_status);
    user_paused_d = (state_q == S_PAUSED);
    rgb_d         = '0;
    for (int unsigned c = 0; c < 3; c++) begin
      rgb_d[c*COLOR_W +: COLOR_W] = rgb_in[c*COLOR_W +: COLOR_W] >> dim_q;
    end
  end

  // State and datapath registers; edge copies track inputs even in reset
  always_ff @(posedge clk_sys) begin
    pause_btn_q <= pause_btn_d;
    step_btn_q  <= step_btn_d;
    vblank_q    <= vblank_d;
    if (reset) begin
      state_q       <= S_RUN;
      timer_q       <= '0;
      step_cnt_q    <= '0;
      dim_q         <= '0;
      pause_q       <= 1'b0;
      user_paused_q <= 1'b0;
      rgb_q         <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      step_cnt_q    <= step_cnt_d;
      dim_q         <= dim_d;
      pause_q       <= pause_d;
      user_paused_q <= user_paused_d;
      rgb_q         <= rgb_d;
    end
  end

  assign rgb_out     = rgb_q;
  assign pause       = pause_q;
  assign user_paused = user_paused_q;
  assign dim_level   = dim_q;

endmodule

// File: doc/pause_ctrl.md
PAUSE_CTRL -- requirements
Module: pause_ctrl

Interface
REQ-001 SHALL provide parameter SRC_COUNT, default 1, meaning number of external pause-request sources.
REQ-002 SHALL provide parameter COLOR_W, default 4, meaning bits per colour channel.
REQ-003 SHALL provide parameter DIM_TIMEOUT, default 240000000, meaning clk_sys cycles of user pause before dimming starts.
REQ-004 SHALL provide parameter DIM_STEP, default 24000000, meaning cycles between successive dim levels.
REQ-005 SHALL provide parameter DIM_MAX, default 1, meaning maximum right-shift applied per channel (legal range 1..COLOR_W-1).
REQ-006 SHALL have port clk_sys, input, 1, the single clock; one clock, all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port user_pause, input, 1, level button; each rising edge is one toggle request.
REQ-009 SHALL have port user_step, input, 1, level button; each rising edge is one frame-advance request.
REQ-010 SHALL have port pause_req, input, SRC_COUNT, level requests that force pause (e.g. hiscore RAM access).
REQ-011 SHALL have ports osd_pause_en and osd_status, inputs, 1 each; pause while both high.
REQ-012 SHALL have port vblank, input, 1, core vertical blank.
REQ-013 SHALL have port rgb_in, input, 3*COLOR_W, {R,G,B} from the core.
REQ-014 SHALL have port rgb_out, output, 3*COLOR_W, dimmed {R,G,B}.
REQ-015 SHALL have ports pause (out 1, to core), user_paused (out 1), dim_level (out, $clog2(DIM_MAX+1)).

Function
REQ-016 SHALL implement states RUN, PAUSED, STEP_A, STEP_B.
REQ-017 SHALL detect rising edges of user_pause, user_step, vblank against a one-cycle registered copy of each.
REQ-018 RUN: toggle edge -> PAUSED; step edge ignored.
REQ-019 PAUSED: toggle edge -> RUN; step edge (no toggle) -> STEP_A; toggle and step in same cycle -> RUN.
REQ-020 STEP_A: vblank rising edge -> STEP_B; STEP_B: vblank rising edge -> PAUSED (exactly one full frame executed).
REQ-021 In STEP_A/STEP_B a toggle edge SHALL go to RUN, taking priority over a vblank edge in the same cycle; step edges ignored.
REQ-022 user_paused SHALL be high in PAUSED only, registered from the state.
REQ-023 pause SHALL be registered, 1-cycle latency: (state==PAUSED) | (|pause_req) | (osd_pause_en & osd_status).
REQ-024 pause_req/OSD pause SHALL NOT change state, timer, or dim level; state transitions continue while they are asserted.
REQ-025 Dim timer SHALL count clk_sys cycles only in PAUSED, saturating at DIM_TIMEOUT; width sufficient for DIM_TIMEOUT without wrap.
REQ-026 On reaching DIM_TIMEOUT, dim_level SHALL become 1, then increment every DIM_STEP cycles, saturating at DIM_MAX.
REQ-027 Leaving PAUSED for any state SHALL clear timer, step counter and dim_level to 0 on the transition cycle.
REQ-028 rgb_out SHALL equal each channel of rgb_in logically right-shifted by dim_level, registered, 1-cycle latency.
REQ-029 dim_level change SHALL take effect on rgb_out the cycle after dim_level updates; no partial-channel mixing within a pixel.

Reset
REQ-030 While reset high: state RUN, pause 0, user_paused 0, dim_level 0, rgb_out 0, timers 0, edge registers loaded with current inputs (no false edge on release).
REQ-031 Reset asserted in any state, including STEP_A/STEP_B mid-frame, SHALL return to RUN on the next clock edge.

Verification (bench: COLOR_W=4, DIM_TIMEOUT=16, DIM_STEP=8, DIM_MAX=2, SRC_COUNT=2)
REQ-032 Pulse user_pause from RUN -> pause=1 and user_paused=1 two cycles after edge; second pulse -> both 0.
REQ-033 Hold PAUSED with rgb_in=12'hFFF -> rgb_out FFF until timer=16, then 777, 8 cycles later 333, stays 333; toggle -> dim_level 0, rgb_out FFF next cycle.
REQ-034 In PAUSED pulse user_step, then two vblank rising edges -> pause 0 between edges, user_paused 1 again after second edge; third vblank edge no effect.
REQ-035 RUN with pause_req=2'b10 for 5 cycles -> pause high 5 cycles delayed by 1, user_paused 0, dim_level stays 0.
REQ-036 Same-cycle toggle+step in PAUSED -> RUN; toggle+vblank edge in STEP_A -> RUN.
REQ-037 Assert reset in STEP_B with dim inputs active -> all outputs 0 next cycle; user_pause held high across reset release causes no toggle.
